// File: rtl/mul_arbiter_if.sv
// Bundle of requester, response and muler handshake signals around mul_arbiter.
// slave = arbiter view, master = environment view (requesters plus muler).
interface mul_arbiter_if #(
  parameter int XLEN = 64
);
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_flush;
  logic            req_mulw0;
  logic            req_mulw1;
  logic [1:0]      req_signed0;
  logic [1:0]      req_signed1;
  logic [XLEN-1:0] req_src1_0;
  logic [XLEN-1:0] req_src1_1;
  logic [XLEN-1:0] req_src2_0;
  logic [XLEN-1:0] req_src2_1;
  logic [1:0]      resp_valid;
  logic [1:0]      resp_ready;
  logic [XLEN-1:0] resp_hi;
  logic [XLEN-1:0] resp_lo;
  logic            mul_valid;
  logic            mul_ready;
  logic            mul_flush;
  logic            mul_mulw;
  logic [1:0]      mul_signed;
  logic [XLEN-1:0] mul_src1;
  logic [XLEN-1:0] mul_src2;
  logic            mul_out_valid;
  logic [XLEN-1:0] mul_result_hi;
  logic [XLEN-1:0] mul_result_lo;

  modport slave (
    input  req_valid, req_flush, req_mulw0, req_mulw1, req_signed0, req_signed1,
    input  req_src1_0, req_src1_1, req_src2_0, req_src2_1, resp_ready,
    input  mul_ready, mul_out_valid, mul_result_hi, mul_result_lo,
    output req_ready, resp_valid, resp_hi, resp_lo,
    output mul_valid, mul_flush, mul_mulw, mul_signed, mul_src1, mul_src2
  );

  modport master (
    output req_valid, req_flush, req_mulw0, req_mulw1, req_signed0, req_signed1,
    output req_src1_0, req_src1_1, req_src2_0, req_src2_1, resp_ready,
    output mul_ready, mul_out_valid, mul_result_hi, mul_result_lo,
    input  req_ready, resp_valid, resp_hi, resp_lo,
    input  mul_valid, mul_flush, mul_mulw, mul_signed, mul_src1, mul_src2
  );
endinterface

// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one muler between two requesters. Round-robin grant,
// operand latch, owner flush forwarding and a one-entry response buffer.
module mul_arbiter #(
  parameter int XLEN = 64
) (
  input  logic         clock,
  input  logic         reset,
  mul_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e          state_q;
  logic            owner_q;
  logic            last_grant_q;
  logic            mul_valid_q;
  logic            mul_flush_q;
  logic            mulw_q;
  logic [1:0]      signed_q;
  logic [XLEN-1:0] src1_q;
  logic [XLEN-1:0] src2_q;
  logic [1:0]      resp_valid_q;
  logic [XLEN-1:0] resp_hi_q;
  logic [XLEN-1:0] resp_lo_q;

  logic [1:0]      eligible_s;
  logic [1:0]      grant_d;
  logic            grant_sel_s;
  logic            owner_flush_s;

  // Round-robin pick among non-flushing requesters; grants only from IDLE.
  always_comb begin
    eligible_s = bus.req_valid & ~bus.req_flush;
    grant_d    = 2'b00;
    if (!reset || (state_q != IDLE)) begin
      grant_d = 2'b00;
    end else if (eligible_s == 2'b11) begin
      // Both eligible: the one that did not win last time goes first.
      grant_d = last_grant_q ? 2'b01 : 2'b10;
    end else begin
      grant_d = eligible_s;
    end
  end

  assign grant_sel_s   = grant_d[1];
  assign owner_flush_s = bus.req_flush[owner_q];

  assign bus.req_ready  = grant_d;
  // An owner flush in ISSUE withdraws the request in the same cycle.
  assign bus.mul_valid  = mul_valid_q & ~owner_flush_s;
  assign bus.mul_flush  = mul_flush_q;
  assign bus.mul_mulw   = mulw_q;
  assign bus.mul_signed = signed_q;
  assign bus.mul_src1   = src1_q;
  assign bus.mul_src2   = src2_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_hi    = resp_hi_q;
  assign bus.resp_lo    = resp_lo_q;

  // Arbitration FSM with registered muler drive and response buffer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mul_valid_q  <= 1'b0;
      mul_flush_q  <= 1'b0;
      mulw_q       <= 1'b0;
      signed_q     <= 2'b00;
      src1_q       <= {XLEN{1'b0}};
      src2_q       <= {XLEN{1'b0}};
      resp_valid_q <= 2'b00;
      resp_hi_q    <= {XLEN{1'b0}};
      resp_lo_q    <= {XLEN{1'b0}};
    end else begin
      // Flush towards the muler is a single-cycle pulse.
      mul_flush_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_d != 2'b00) begin
            owner_q      <= grant_sel_s;
            last_grant_q <= grant_sel_s;
            mulw_q       <= grant_sel_s ? bus.req_mulw1   : bus.req_mulw0;
            signed_q     <= grant_sel_s ? bus.req_signed1 : bus.req_signed0;
            src1_q       <= grant_sel_s ? bus.req_src1_1  : bus.req_src1_0;
            src2_q       <= grant_sel_s ? bus.req_src2_1  : bus.req_src2_0;
            mul_valid_q  <= 1'b1;
            state_q      <= ISSUE;
          end else begin
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          if (owner_flush_s) begin
            mul_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else if (bus.mul_ready) begin
            mul_valid_q <= 1'b0;
            state_q     <= BUSY;
          end else begin
            state_q <= ISSUE;
          end
        end
        BUSY: begin
          // Flush wins over a result arriving in the same cycle.
          if (owner_flush_s) begin
            mul_flush_q <= 1'b1;
            state_q     <= IDLE;
          end else if (bus.mul_out_valid) begin
            resp_hi_q    <= bus.mul_result_hi;
            resp_lo_q    <= bus.mul_result_lo;
            resp_valid_q <= owner_q ? 2'b10 : 2'b01;
            state_q      <= RESP;
          end else begin
            state_q <= BUSY;
          end
        end
        RESP: begin
          if (owner_flush_s || bus.resp_ready[owner_q]) begin
            resp_valid_q <= 2'b00;
            state_q      <= IDLE;
          end else begin
            state_q <= RESP;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed self-checking bench for mul_arbiter; the muler is modelled by tasks.
module tb_mul_arbiter;

  localparam logic [63:0] NEG3  = 64'hFFFF_FFFF_FFFF_FFFD;
  localparam logic [63:0] NEG15 = 64'hFFFF_FFFF_FFFF_FFF1;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  mul_arbiter_if #(.XLEN(64)) bus();

  mul_arbiter #(.XLEN(64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pulse reset mid-cycle and return 1 time unit after a rising edge.
  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
  endtask

  // Muler model: called in ISSUE with mul_ready=1; strobes result after lat cycles.
  task automatic muler_run(input logic [63:0] hi, input logic [63:0] lo, input int lat);
    tick();
    for (int k = 1; k < lat; k++) tick();
    bus.mul_out_valid = 1'b1;
    bus.mul_result_hi = hi;
    bus.mul_result_lo = lo;
    tick();
    bus.mul_out_valid = 1'b0;
    bus.mul_result_hi = 64'd0;
    bus.mul_result_lo = 64'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    bus.req_valid = 2'b11;
    #1;
    n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 00", bus.req_ready); end
    n_checks++; if (bus.resp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 00", bus.resp_valid); end
    n_checks++; if (bus.mul_valid !== 1'b0 || bus.mul_flush !== 1'b0 || bus.mul_mulw !== 1'b0) begin n_fail++; $display("FAIL reset_mul_ctrl: got v=%b f=%b w=%b expected 0", bus.mul_valid, bus.mul_flush, bus.mul_mulw); end
    n_checks++; if (bus.mul_src1 !== 64'd0 || bus.mul_src2 !== 64'd0 || bus.mul_signed !== 2'b00) begin n_fail++; $display("FAIL reset_mul_ops: got %h %h %b expected zero", bus.mul_src1, bus.mul_src2, bus.mul_signed); end
    n_checks++; if (bus.resp_hi !== 64'd0 || bus.resp_lo !== 64'd0) begin n_fail++; $display("FAIL reset_resp_data: got %h %h expected zero", bus.resp_hi, bus.resp_lo); end
    tick();
    tick();
    n_checks++; if (bus.mul_valid !== 1'b0) begin n_fail++; $display("FAIL reset_held_mul_valid: got %b expected 0", bus.mul_valid); end
    bus.req_valid = 2'b00;
    #2;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_op();
    do_reset();
    bus.mul_ready   = 1'b1;
    bus.req_valid   = 2'b01;
    bus.req_src1_0  = 64'd7;
    bus.req_src2_0  = 64'd6;
    bus.req_mulw0   = 1'b0;
    bus.req_signed0 = 2'b11;
    #1;
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b expected 01", bus.req_ready); end
    n_checks++; if (bus.mul_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_early_valid: got %b expected 0", bus.mul_valid); end
    tick();
    bus.req_valid = 2'b00;
    n_checks++; if (bus.mul_valid !== 1'b1) begin n_fail++; $display("FAIL single_mul_valid: got %b expected 1", bus.mul_valid); end
    n_checks++; if (bus.mul_src1 !== 64'd7 || bus.mul_src2 !== 64'd6) begin n_fail++; $display("FAIL single_operands: got %h %h expected 7 6", bus.mul_src1, bus.mul_src2); end
    n_checks++; if (bus.mul_signed !== 2'b11 || bus.mul_mulw !== 1'b0) begin n_fail++; $display("FAIL single_ctrl: got s=%b w=%b expected 11 0", bus.mul_signed, bus.mul_mulw); end
    muler_run(64'd0, 64'd42, 5);
    n_checks++; if (bus.resp_valid !== 2'b01) begin n_fail++; $display("FAIL single_resp_valid: got %b expected 01", bus.resp_valid); end
    n_checks++; if (bus.resp_lo !== 64'd42 || bus.resp_hi !== 64'd0) begin n_fail++; $display("FAIL single_resp_data: got %h %h expected 0 42", bus.resp_hi, bus.resp_lo); end
    tick();
    tick();
    n_checks++; if (bus.resp_valid !== 2'b01 || bus.resp_lo !== 64'd42) begin n_fail++; $display("FAIL single_resp_hold: got %b %h expected 01 42", bus.resp_valid, bus.resp_lo); end
    bus.resp_ready = 2'b01;
    tick();
    bus.resp_ready = 2'b00;
    n_checks++; if (bus.resp_valid !== 2'b00) begin n_fail++; $display("FAIL single_consume: got %b expected 00", bus.resp_valid); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    do_reset();
    bus.mul_ready   = 1'b1;
    bus.req_valid   = 2'b11;
    bus.req_src1_0  = 64'd2;
    bus.req_src2_0  = 64'd3;
    bus.req_signed0 = 2'b00;
    bus.req_src1_1  = NEG3;
    bus.req_src2_1  = 64'd5;
    bus.req_signed1 = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_g = ((i % 2) == 0) ? 2'b01 : 2'b10;
      #1;
      n_checks++; if (bus.req_ready !== exp_g) begin n_fail++; $display("FAIL rr_grant_%0d: got %b expected %b", i, bus.req_ready, exp_g); end
      tick();
      if ((i % 2) == 1) begin
        n_checks++; if (bus.mul_src1 !== NEG3 || bus.mul_signed !== 2'b11) begin n_fail++; $display("FAIL rr_p1_operands_%0d: got %h %b expected %h 11", i, bus.mul_src1, bus.mul_signed, NEG3); end
        muler_run(ONES, NEG15, 3);
        n_checks++; if (bus.resp_lo !== NEG15 || bus.resp_hi !== ONES) begin n_fail++; $display("FAIL rr_p1_result_%0d: got %h %h expected %h %h", i, bus.resp_hi, bus.resp_lo, ONES, NEG15); end
      end else begin
        n_checks++; if (bus.mul_src1 !== 64'd2 || bus.mul_src2 !== 64'd3) begin n_fail++; $display("FAIL rr_p0_operands_%0d: got %h %h expected 2 3", i, bus.mul_src1, bus.mul_src2); end
        muler_run(64'd0, 64'd6, 3);
        n_checks++; if (bus.resp_lo !== 64'd6) begin n_fail++; $display("FAIL rr_p0_result_%0d: got %h expected 6", i, bus.resp_lo); end
      end
      n_checks++; if (bus.resp_valid !== exp_g) begin n_fail++; $display("FAIL rr_resp_valid_%0d: got %b expected %b", i, bus.resp_valid, exp_g); end
      bus.resp_ready = exp_g;
      tick();
      bus.resp_ready = 2'b00;
    end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.mul_ready  = 1'b1;
    bus.req_valid  = 2'b01;
    bus.req_src1_0 = 64'd7;
    bus.req_src2_0 = 64'd6;
    tick();
    bus.req_valid = 2'b11;
    muler_run(64'd0, 64'd42, 2);
    for (int i = 0; i < 10; i++) begin
      bus.resp_ready = (i == 5) ? 2'b10 : 2'b00;
      #1;
      n_checks++; if (bus.resp_valid !== 2'b01 || bus.resp_lo !== 64'd42) begin n_fail++; $display("FAIL bp_hold_%0d: got %b %h expected 01 42", i, bus.resp_valid, bus.resp_lo); end
      n_checks++; if (bus.req_ready !== 2'b00 || bus.mul_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_grant_%0d: got rdy=%b mv=%b expected 00 0", i, bus.req_ready, bus.mul_valid); end
      tick();
    end
    bus.resp_ready = 2'b01;
    #1;
    n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_consume_no_grant: got %b expected 00", bus.req_ready); end
    tick();
    bus.resp_ready = 2'b00;
    n_checks++; if (bus.resp_valid !== 2'b00) begin n_fail++; $display("FAIL bp_consumed: got %b expected 00", bus.resp_valid); end
    #1;
    n_checks++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_next_grant: got %b expected 10", bus.req_ready); end
    bus.req_valid = 2'b00;
    tick();
  endtask

  task automatic test_flush_busy();
    int pulses;
    do_reset();
    bus.mul_ready  = 1'b1;
    bus.req_valid  = 2'b01;
    bus.req_src1_0 = 64'd3;
    bus.req_src2_0 = 64'd4;
    tick();
    bus.req_valid = 2'b00;
    tick();
    n_checks++; if (bus.mul_valid !== 1'b0) begin n_fail++; $display("FAIL fb_valid_drop: got %b expected 0", bus.mul_valid); end
    tick();
    bus.req_flush = 2'b01;
    #1;
    n_checks++; if (bus.mul_flush !== 1'b0) begin n_fail++; $display("FAIL fb_no_early_flush: got %b expected 0", bus.mul_flush); end
    tick();
    bus.req_flush = 2'b00;
    n_checks++; if (bus.mul_flush !== 1'b1) begin n_fail++; $display("FAIL fb_flush_pulse: got %b expected 1", bus.mul_flush); end
    n_checks++; if (bus.resp_valid !== 2'b00) begin n_fail++; $display("FAIL fb_no_resp: got %b expected 00", bus.resp_valid); end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      bus.mul_out_valid = (i == 1) ? 1'b1 : 1'b0;
      bus.mul_result_lo = 64'd123;
      tick();
      if (bus.mul_flush === 1'b1) pulses++;
    end
    bus.mul_out_valid = 1'b0;
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL fb_single_pulse: got %0d extra pulses expected 0", pulses); end
    n_checks++; if (bus.resp_valid !== 2'b00 || bus.resp_lo !== 64'd0) begin n_fail++; $display("FAIL fb_late_result_ignored: got %b %h expected 00 0", bus.resp_valid, bus.resp_lo); end
    bus.req_valid = 2'b01;
    #1;
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL fb_back_to_idle: got %b expected 01", bus.req_ready); end
    bus.req_valid = 2'b00;
    tick();
  endtask

  task automatic test_flush_issue();
    do_reset();
    bus.mul_ready   = 1'b0;
    bus.req_valid   = 2'b01;
    bus.req_mulw0   = 1'b1;
    bus.req_signed0 = 2'b01;
    bus.req_src1_0  = 64'd11;
    bus.req_src2_0  = 64'd12;
    tick();
    bus.req_valid = 2'b00;
    n_checks++; if (bus.mul_valid !== 1'b1 || bus.mul_mulw !== 1'b1 || bus.mul_signed !== 2'b01) begin n_fail++; $display("FAIL fi_issue: got v=%b w=%b s=%b expected 1 1 01", bus.mul_valid, bus.mul_mulw, bus.mul_signed); end
    tick();
    n_checks++; if (bus.mul_valid !== 1'b1 || bus.mul_src1 !== 64'd11) begin n_fail++; $display("FAIL fi_stall_hold: got %b %h expected 1 11", bus.mul_valid, bus.mul_src1); end
    bus.req_flush = 2'b01;
    #1;
    n_checks++; if (bus.mul_valid !== 1'b0) begin n_fail++; $display("FAIL fi_valid_forced_low: got %b expected 0", bus.mul_valid); end
    tick();
    bus.req_flush = 2'b00;
    n_checks++; if (bus.mul_valid !== 1'b0 || bus.mul_flush !== 1'b0) begin n_fail++; $display("FAIL fi_after_flush: got v=%b f=%b expected 0 0", bus.mul_valid, bus.mul_flush); end
    bus.mul_ready = 1'b1;
    bus.req_valid = 2'b01;
    bus.req_mulw0 = 1'b0;
    #1;
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL fi_idle_regrant: got %b expected 01", bus.req_ready); end
    tick();
    bus.req_valid = 2'b00;
    tick();
    bus.req_flush = 2'b10;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (bus.mul_flush !== 1'b0) begin n_fail++; $display("FAIL fi_nonowner_flush_%0d: got %b expected 0", i, bus.mul_flush); end
    end
    bus.req_flush     = 2'b00;
    bus.mul_out_valid = 1'b1;
    bus.mul_result_hi = 64'd1;
    bus.mul_result_lo = 64'd99;
    tick();
    bus.mul_out_valid = 1'b0;
    n_checks++; if (bus.resp_valid !== 2'b01 || bus.resp_lo !== 64'd99 || bus.resp_hi !== 64'd1) begin n_fail++; $display("FAIL fi_owner_result: got %b %h %h expected 01 1 99", bus.resp_valid, bus.resp_hi, bus.resp_lo); end
    bus.resp_ready = 2'b01;
    tick();
    bus.resp_ready = 2'b00;
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.mul_ready  = 1'b1;
    bus.req_valid  = 2'b01;
    bus.req_src1_0 = 64'd9;
    bus.req_src2_0 = 64'd9;
    tick();
    bus.req_valid = 2'b00;
    muler_run(64'd5, 64'd77, 2);
    n_checks++; if (bus.resp_valid !== 2'b01 || bus.resp_lo !== 64'd77) begin n_fail++; $display("FAIL ar_in_resp: got %b %h expected 01 77", bus.resp_valid, bus.resp_lo); end
    #3;
    reset = 1'b0;
    #1;
    n_checks++; if (bus.resp_valid !== 2'b00 || bus.resp_lo !== 64'd0 || bus.resp_hi !== 64'd0) begin n_fail++; $display("FAIL ar_resp_cleared: got %b %h %h expected zero", bus.resp_valid, bus.resp_hi, bus.resp_lo); end
    n_checks++; if (bus.mul_src1 !== 64'd0 || bus.mul_flush !== 1'b0 || bus.mul_valid !== 1'b0) begin n_fail++; $display("FAIL ar_mul_cleared: got %h f=%b v=%b expected zero", bus.mul_src1, bus.mul_flush, bus.mul_valid); end
    bus.req_valid = 2'b11;
    #1;
    n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL ar_no_grant_in_reset: got %b expected 00", bus.req_ready); end
    #1;
    reset = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL ar_port0_first: got %b expected 01", bus.req_ready); end
    bus.req_valid = 2'b00;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks          = 0;
    n_fail            = 0;
    reset             = 1'b1;
    bus.req_valid     = 2'b00;
    bus.req_flush     = 2'b00;
    bus.req_mulw0     = 1'b0;
    bus.req_mulw1     = 1'b0;
    bus.req_signed0   = 2'b00;
    bus.req_signed1   = 2'b00;
    bus.req_src1_0    = 64'd0;
    bus.req_src1_1    = 64'd0;
    bus.req_src2_0    = 64'd0;
    bus.req_src2_1    = 64'd0;
    bus.resp_ready    = 2'b00;
    bus.mul_ready     = 1'b0;
    bus.mul_out_valid = 1'b0;
    bus.mul_result_hi = 64'd0;
    bus.mul_result_lo = 64'd0;

    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_flush_busy();
    test_flush_issue();
    test_async_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
